dcache_port_master: RTL and testbench
=====================================

Name: dcache_port_master

Overview:
- Initiator side of the DataCache single-port block-RAM interface (clka/ena/wea/addra/dina/douta).
- Accepts load/store requests from the core over a valid/ready handshake and drives the RAM port with registered signals.
- Waits out the RAM read latency and returns a one-cycle response.
- Implements sub-word stores as read-modify-write, because the RAM has a single-bit write enable.

Parameters:
- ADDR_W, 13, word address width; matches addra.
- DATA_W, 32, data width; must be a multiple of 8.
- RD_LAT, 1, clock edges from ena=1 with wea=0 until douta holds the read data. Legal values 1..3.

Ports:
- clka  in  1  clock; all logic on the rising edge.
- rsta  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  byte enables for stores; bit i covers bits [8i+7:8i]; ignored for loads.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_W  load data, or the pre-store word for an RMW store.
- ena  out  1  RAM enable.
- wea  out  1  RAM write enable (wea[0:0] at the RAM).
- addra  out  ADDR_W  RAM address.
- dina  out  DATA_W  RAM write data.
- douta  in  DATA_W  RAM read data.

Behaviour:
- Clock is clka; reset is rsta, synchronous and active-high. One clock domain.
- Reset values: ena=0, wea=0, addra=0, dina=0, rsp_valid=0, rsp_rdata=0, state=IDLE.
  - req_ready=0 while rsta=1; req_ready=1 in the first cycle after rsta deasserts.
- FSM states: IDLE, RD_WAIT, MERGE, WR, RESP.
  - req_ready=1 only in IDLE; one transaction outstanding at a time.
  - Handshake occurs in cycle N when req_valid & req_ready. All request fields are latched in cycle N.
  - ena, wea, addra and dina are registered. An access decided in cycle N appears on the port in cycle N+1, and ena/wea are high for exactly one cycle per access.
- Load:
  - IDLE -> RD_WAIT; ena=1, wea=0, addra=req_addr in N+1.
  - douta is sampled in cycle N+1+RD_LAT and registered into rsp_rdata.
  - rsp_valid=1 in cycle N+2+RD_LAT; state goes through RESP, then IDLE.
  - req_ready=1 again in N+3+RD_LAT.
- Full store (req_be all ones):
  - ena=1, wea=1, dina=req_wdata in N+1.
  - rsp_valid=1 in N+2, rsp_rdata=0; IDLE and req_ready=1 in N+3.
- Partial store (req_be neither all zeros nor all ones):
  - Read phase identical to a load: old word captured in N+1+RD_LAT.
  - MERGE: new word = (old & ~mask) | (wdata & mask), where mask expands req_be to bytes.
  - WR: ena=1, wea=1, dina=merged word in N+2+RD_LAT.
  - rsp_valid=1 in N+3+RD_LAT with rsp_rdata = old word.
- Store with req_be=0: no RAM access (ena stays 0); rsp_valid=1 in N+2, rsp_rdata=0.
- Between accesses: addra and dina hold their last values; ena=0, wea=0.
- Mid-operation reset: at the next edge all outputs return to reset values and state returns to IDLE.
  - An RMW interrupted before WR leaves the RAM word unmodified.
  - No rsp_valid is issued for the aborted request.
- req_valid deasserted in IDLE: no RAM activity.
- A request presented while req_ready=0 is neither latched nor lost; the requester holds it until req_ready=1.
- Address wrap: none. addra is exactly the latched req_addr; all 2^ADDR_W words are reachable, including 0 and 13'h1FFF.

Optional Feature:
- Macro: DCP_LAST_WRITE_FWD_EN.
- Defined:
  - Keeps a valid bit plus the address and data of the last completed store (merged word for RMW). Valid clears on rsta.
  - A load whose address matches a valid entry skips the RAM access: ena stays 0, rsp_valid=1 in N+2 with the stored word.
  - Any store updates the entry.
- Undefined: all loads access the RAM as described in Behaviour; the entry logic is absent.

Test Plan:
- Reset release: rsta high 3 cycles then low -> all outputs 0 during reset; req_ready=1 on the first cycle after; no ena pulse.
- Full store then load: store 500 to 13'h0238 with be=4'hF; store 120 to 13'h1238; load 13'h0238 -> rsp_rdata=500.
  - Checks: rsp_valid at N+2+RD_LAT for the load; exactly one ena pulse per request; wea=0 on the load.
- Partial store (RMW): 13'h0010 holds 32'hAABBCCDD; store 32'h11223344 with be=4'b0101 -> RAM then holds 32'hAA22CC44; response rsp_rdata=32'hAABBCCDD.
  - Checks: the wea pulse lands at N+2+RD_LAT.
- Zero byte-enable store to 13'h0238 -> no ena pulse; rsp_valid at N+2; a following load of 13'h0238 still returns 500.
- Back-to-back requests with req_valid held high -> req_ready low throughout each transaction; each request accepted once; rsp_valid pulse count equals handshake count. Repeat with RD_LAT=2.
- Reset mid-RMW: assert rsta in the MERGE cycle -> no wea pulse, no rsp_valid, RAM word unchanged, req_ready=1 after release.
  - With DCP_LAST_WRITE_FWD_EN defined: a load to the last-stored address returns its data at N+2 with ena=0.

Source files
------------

// File: rtl/dcache_port_master.sv
// Core-side initiator for the DataCache single-port block RAM: loads, full stores and
// byte-enable stores done as read-modify-write. Optional last-store forwarding: DCP_LAST_WRITE_FWD_EN.
module dcache_port_master #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              ena,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   input  logic [DATA_W-1:0] douta
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT);
   localparam logic [1:0] LAT_PRE  = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WR, RESP} state_t;

   state_t            state_q;
   logic              ready_q;
   logic              ena_q;
   logic              wea_q;
   logic              rsp_valid_q;
   logic              rmw_q;
   logic [1:0]        cnt_q;
   logic [ADDR_W-1:0] addra_q;
   logic [DATA_W-1:0] dina_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] mask_d;
   logic [DATA_W-1:0] merged_d;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   for (genvar gi = 0; gi < BE_W; gi++) begin : g_mask
      assign mask_d[8*gi +: 8] = {8{be_q[gi]}};
   end

   assign merged_d = (douta & ~mask_d) | (wdata_q & mask_d);

`ifdef DCP_LAST_WRITE_FWD_EN
   logic              fwd_valid_q;
   logic [ADDR_W-1:0] fwd_addr_q;
   logic [DATA_W-1:0] fwd_data_q;

   assign fwd_hit  = fwd_valid_q && (fwd_addr_q == req_addr);
   assign fwd_data = fwd_data_q;

   // The word on dina during a WR-state write is exactly what the RAM now holds.
   always_ff @(posedge clka) begin
      if (rsta) begin
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
      end else if (state_q == WR && wea_q) begin
         fwd_valid_q <= 1'b1;
         fwd_addr_q  <= addra_q;
         fwd_data_q  <= dina_q;
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         ena_q       <= 1'b0;
         wea_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rmw_q       <= 1'b0;
         cnt_q       <= '0;
         addra_q     <= '0;
         dina_q      <= '0;
         rsp_rdata_q <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
      end else begin
         ena_q       <= 1'b0;
         wea_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  cnt_q   <= '0;
                  if (!req_we && fwd_hit) begin
                     rsp_rdata_q <= fwd_data;
                     state_q     <= WR;
                  end else if (!req_we) begin
                     ena_q   <= 1'b1;
                     addra_q <= req_addr;
                     rmw_q   <= 1'b0;
                     state_q <= RD_WAIT;
                  end else if (&req_be) begin
                     ena_q       <= 1'b1;
                     wea_q       <= 1'b1;
                     addra_q     <= req_addr;
                     dina_q      <= req_wdata;
                     rsp_rdata_q <= '0;
                     state_q     <= WR;
                  end else if (req_be == '0) begin
                     // Nothing to write: answer without touching the RAM port.
                     rsp_rdata_q <= '0;
                     state_q     <= WR;
                  end else begin
                     ena_q   <= 1'b1;
                     addra_q <= req_addr;
                     rmw_q   <= 1'b1;
                     state_q <= RD_WAIT;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            RD_WAIT: begin
               cnt_q <= cnt_q + 2'd1;
               // RMW leaves one cycle early so MERGE coincides with douta becoming valid.
               if (rmw_q && cnt_q == LAT_PRE) begin
                  state_q <= MERGE;
               end else if (!rmw_q && cnt_q == LAT_LAST) begin
                  rsp_rdata_q <= douta;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            MERGE: begin
               rsp_rdata_q <= douta;
               dina_q      <= merged_d;
               ena_q       <= 1'b1;
               wea_q       <= 1'b1;
               state_q     <= WR;
            end
            WR: begin
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign ena       = ena_q;
   assign wea       = wea_q;
   assign addra     = addra_q;
   assign dina      = dina_q;

endmodule

// File: tb/tb_dcache_port_master.sv
// Drives two port masters (RD_LAT=1 and RD_LAT=2), each with its own RAM model,
// and checks responses, port timing and RAM contents against a word-level memory model.
`timescale 1ns/1ps
module tb_dcache_port_master;
   localparam int NI = 2;
   localparam int AW = 13;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rsta      [NI];
   logic          req_valid [NI];
   logic          req_ready [NI];
   logic          req_we    [NI];
   logic [AW-1:0] req_addr  [NI];
   logic [DW-1:0] req_wdata [NI];
   logic [3:0]    req_be    [NI];
   logic          rsp_valid [NI];
   logic [DW-1:0] rsp_rdata [NI];
   logic          ena       [NI];
   logic          wea       [NI];
   logic [AW-1:0] addra     [NI];
   logic [DW-1:0] dina      [NI];
   logic [DW-1:0] douta     [NI];

   logic [DW-1:0] mem   [NI][1 << AW];
   bit            mem_v [NI][1 << AW];

   int     total = 0;
   int     bad = 0;
   longint cyc = 0;
   int     ena_cnt [NI];
   int     wea_cnt [NI];
   int     rsp_cnt [NI];
   longint wea_cyc [NI];

   logic [DW-1:0] ref_mem [int];
   bit            fwd_v [NI];
   logic [AW-1:0] fwd_a [NI];

   function automatic logic [DW-1:0] init_word(int s, int a);
      if (a == 16) return 32'hAABBCCDD;
      return (32'(a) * 32'h9E3779B1) ^ (32'(s) << 28);
   endfunction

   function automatic logic [DW-1:0] ref_rd(int s, int a);
      int key = s * 8192 + a;
      if (ref_mem.exists(key)) return ref_mem[key];
      return init_word(s, a);
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int L = gi + 1;
      logic [DW-1:0] pipe [L];

      dcache_port_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
         .clka      (clk),
         .rsta      (rsta[gi]),
         .req_valid (req_valid[gi]),
         .req_ready (req_ready[gi]),
         .req_we    (req_we[gi]),
         .req_addr  (req_addr[gi]),
         .req_wdata (req_wdata[gi]),
         .req_be    (req_be[gi]),
         .rsp_valid (rsp_valid[gi]),
         .rsp_rdata (rsp_rdata[gi]),
         .ena       (ena[gi]),
         .wea       (wea[gi]),
         .addra     (addra[gi]),
         .dina      (dina[gi]),
         .douta     (douta[gi])
      );

      always @(posedge clk) begin
         if (ena[gi] === 1'b1) begin
            if (wea[gi] === 1'b1) begin
               mem[gi][addra[gi]]   <= dina[gi];
               mem_v[gi][addra[gi]] <= 1'b1;
            end else begin
               pipe[0] <= mem_v[gi][addra[gi]] ? mem[gi][addra[gi]] : init_word(gi, int'(addra[gi]));
            end
         end
         for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
      end
      assign douta[gi] = pipe[L-1];
   end

   always @(posedge clk) begin
      for (int s = 0; s < NI; s++) begin
         if (ena[s] === 1'b1) ena_cnt[s] <= ena_cnt[s] + 1;
         if (wea[s] === 1'b1) begin
            wea_cnt[s] <= wea_cnt[s] + 1;
            wea_cyc[s] <= cyc;
         end
         if (rsp_valid[s] === 1'b1) rsp_cnt[s] <= rsp_cnt[s] + 1;
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input int s, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [3:0] be);
      req_valid[s] = 1'b1;
      req_we[s]    = we;
      req_addr[s]  = a;
      req_wdata[s] = wd;
      req_be[s]    = be;
   endtask

   // Runs the request currently on the bus; with b2b the next one is presented right after the handshake.
   task automatic txn(input int s, input bit b2b, input logic nwe, input logic [AW-1:0] naddr,
                      input logic [DW-1:0] nwd, input logic [3:0] nbe);
      int            nw = 0;
      longint        n;
      int            e0, w0, en, wn, wk, rk, pulses, busy;
      bit            hit;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, old, nxt, exp_d;
      logic [3:0]    be;
      int            lat = s + 1;
      while (req_ready[s] !== 1'b1) begin
         @(posedge clk); #1;
         nw++;
         if (nw > 40) begin
            chk("ready_timeout", 64'(req_ready[s]), 64'd1);
            req_valid[s] = 1'b0;
            return;
         end
      end
      n = cyc; e0 = ena_cnt[s]; w0 = wea_cnt[s];
      we = req_we[s]; a = req_addr[s]; wd = req_wdata[s]; be = req_be[s];
      old = ref_rd(s, int'(a));
      nxt = old;
      wk = 0;
`ifdef DCP_LAST_WRITE_FWD_EN
      hit = fwd_v[s] && (fwd_a[s] == a);
`else
      hit = 1'b0;
`endif
      if (!we) begin
         en = hit ? 0 : 1; wn = 0; rk = hit ? 2 : 2 + lat; exp_d = old;
      end else if (be == 4'hF) begin
         en = 1; wn = 1; wk = 1; rk = 2; exp_d = '0; nxt = wd;
      end else if (be == 4'h0) begin
         en = 0; wn = 0; rk = 2; exp_d = '0;
      end else begin
         en = 2; wn = 1; wk = 2 + lat; rk = 3 + lat; exp_d = old;
         for (int i = 0; i < 4; i++) if (be[i]) nxt[8*i +: 8] = wd[8*i +: 8];
      end
      @(posedge clk); #1;
      if (b2b) present(s, nwe, naddr, nwd, nbe);
      else req_valid[s] = 1'b0;
      pulses = 0; busy = 0;
      for (int k = 1; k <= rk + 1; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (rsp_valid[s] === 1'b1) pulses++;
         if (k == rk) begin
            chk("rsp_valid_at_slot", 64'(rsp_valid[s]), 64'd1);
            chk("rsp_rdata", 64'(rsp_rdata[s]), 64'(exp_d));
         end
         if (k <= rk && req_ready[s] !== 1'b0) busy++;
      end
      chk("ready_low_while_busy", 64'(busy), 64'd0);
      chk("ready_back", 64'(req_ready[s]), 64'd1);
      chk("rsp_pulses", 64'(pulses), 64'd1);
      chk("ena_pulses", 64'(ena_cnt[s] - e0), 64'(en));
      chk("wea_pulses", 64'(wea_cnt[s] - w0), 64'(wn));
      if (wn != 0) chk("wea_cycle", 64'(wea_cyc[s]), 64'(n + longint'(wk)));
      if (we && be != 4'h0) begin
         ref_mem[s * 8192 + int'(a)] = nxt;
         fwd_v[s] = 1'b1;
         fwd_a[s] = a;
      end
      $display("txn lat=%0d we=%0d addr=%h wdata=%h be=%h rdata=%h", lat, we, a, wd, be, rsp_rdata[s]);
   endtask

   task automatic rand_req(output logic we, output logic [AW-1:0] a,
                           output logic [DW-1:0] wd, output logic [3:0] be);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 4))
         0: a = 13'h0000;
         1: a = 13'h1FFF;
         2: a = 13'h0238;
         3: a = 13'h0010;
         default: a = 13'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: be = 4'hF;
         1: be = 4'h0;
         default: be = 4'($urandom);
      endcase
   endtask

   initial begin
      logic          rwe;
      logic [AW-1:0] ra;
      logic [DW-1:0] rwd;
      logic [3:0]    rbe;
      logic [DW-1:0] old;
      int            e0, w0, r0;
      for (int s = 0; s < NI; s++) begin
         rsta[s] = 1'b1;
         present(s, 1'b0, '0, '0, '0);
         req_valid[s] = 1'b0;
      end

      // Reset held for three edges, outputs must be at reset values.
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1;
         for (int s = 0; s < NI; s++) begin
            chk("rst_ctl", 64'({ena[s], wea[s], rsp_valid[s], req_ready[s]}), 64'd0);
            chk("rst_addra", 64'(addra[s]), 64'd0);
            chk("rst_dina", 64'(dina[s]), 64'd0);
            chk("rst_rdata", 64'(rsp_rdata[s]), 64'd0);
         end
      end
      for (int s = 0; s < NI; s++) rsta[s] = 1'b0;
      @(posedge clk); #1;
      for (int s = 0; s < NI; s++) chk("ready_after_reset", 64'(req_ready[s]), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < NI; s++) chk("idle_no_ena", 64'(ena_cnt[s]), 64'd0);

      for (int s = 0; s < NI; s++) begin
         present(s, 1'b1, 13'h0238, 32'd500, 4'hF); txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b1, 13'h1238, 32'd120, 4'hF); txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b0, 13'h0238, '0, '0);        txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b1, 13'h0010, 32'h11223344, 4'b0101); txn(s, 0, 0, '0, '0, '0);
         chk("rmw_ram_word", 64'(mem[s][16]), 64'h00000000AA22CC44);
         present(s, 1'b0, 13'h0010, '0, '0);        txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b1, 13'h0238, 32'hDEADBEEF, 4'h0); txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b0, 13'h0238, '0, '0);        txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b1, 13'h0000, 32'h0BADF00D, 4'hF); txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b1, 13'h1FFF, 32'hCAFE1234, 4'b1000); txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b0, 13'h0000, '0, '0);        txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b0, 13'h1FFF, '0, '0);        txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b1, 13'h0777, 32'h55AA00FF, 4'hF); txn(s, 0, 0, '0, '0, '0);
         present(s, 1'b0, 13'h0777, '0, '0);        txn(s, 0, 0, '0, '0, '0);
      end

      // Back-to-back random traffic with req_valid held high.
      for (int s = 0; s < NI; s++) begin
         rand_req(rwe, ra, rwd, rbe);
         present(s, rwe, ra, rwd, rbe);
         for (int i = 0; i < 24; i++) begin
            rand_req(rwe, ra, rwd, rbe);
            txn(s, i < 23, rwe, ra, rwd, rbe);
         end
      end

      // Reset asserted during the MERGE cycle of a read-modify-write.
      for (int s = 0; s < NI; s++) begin
         old = ref_rd(s, 13'h0555);
         present(s, 1'b1, 13'h0555, 32'h01020304, 4'b0011);
         chk("mid_rst_ready", 64'(req_ready[s]), 64'd1);
         e0 = ena_cnt[s]; w0 = wea_cnt[s]; r0 = rsp_cnt[s];
         @(posedge clk); #1;
         req_valid[s] = 1'b0;
         repeat (s + 1) @(posedge clk);
         #1;
         rsta[s] = 1'b1;
         @(posedge clk); #1;
         chk("mid_rst_ctl", 64'({ena[s], wea[s], rsp_valid[s], req_ready[s]}), 64'd0);
         chk("mid_rst_rdata", 64'(rsp_rdata[s]), 64'd0);
         rsta[s] = 1'b0;
         fwd_v[s] = 1'b0;
         @(posedge clk); #1;
         chk("mid_rst_ready_back", 64'(req_ready[s]), 64'd1);
         repeat (4) @(posedge clk);
         #1;
         chk("mid_rst_ena", 64'(ena_cnt[s] - e0), 64'd1);
         chk("mid_rst_wea", 64'(wea_cnt[s] - w0), 64'd0);
         chk("mid_rst_rsp", 64'(rsp_cnt[s] - r0), 64'd0);
         chk("mid_rst_ram", 64'(mem_v[s][13'h0555] ? mem[s][13'h0555] : init_word(s, 13'h0555)), 64'(old));
         present(s, 1'b0, 13'h0555, '0, '0); txn(s, 0, 0, '0, '0, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=1 expected=0");
      $fatal(1, "global timeout");
   end

endmodule
